// File: rtl/except_collect_pkg.sv
// except_collect shared definitions: exception bit positions, size codes,
// pipeline entry bundle and the memory alignment helper.
package except_collect_pkg;

    localparam int EXC_W = 9;

    localparam int EXC_ADEP         = 0;
    localparam int EXC_INSTRINVALID = 1;
    localparam int EXC_OV           = 2;
    localparam int EXC_SYSCALL      = 3;
    localparam int EXC_BREAK        = 4;
    localparam int EXC_ADES         = 5;
    localparam int EXC_ADEL         = 6;
    localparam int EXC_ERET         = 7;
    localparam int EXC_RSVD         = 8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] ZEROWORD = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic             ds;
        logic [EXC_W-1:0] exc;
    } exc_entry_t;

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr);
        logic m;
        m = 1'b0;
        case (size)
            SIZE_HALF: m = addr[0];
            SIZE_WORD: m = (addr != 2'b00);
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/except_collect_if.sv
// except_collect pipeline-side bundle: fetch, stall/flush, decode,
// execute and memory inputs plus the M-stage exception outputs.
interface except_collect_if;

    logic [31:0] pc_f;
    logic        valid_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush;
    logic        invalid_d;
    logic        syscall_d;
    logic        break_d;
    logic        eret_d;
    logic        branch_d;
    logic        ov_e;
    logic [31:0] mem_addr_m;
    logic        load_m;
    logic        store_m;
    logic [1:0]  size_m;
    logic [8:0]  ExceptTypeM;
    logic [31:0] ExceptAddr;
    logic        InDelaySlotM;
    logic [31:0] BadAddrM;
    logic        valid_m;

    modport master (
        output pc_f, valid_f, stall_d, stall_e, stall_m, flush,
        output invalid_d, syscall_d, break_d, eret_d, branch_d, ov_e,
        output mem_addr_m, load_m, store_m, size_m,
        input  ExceptTypeM, ExceptAddr, InDelaySlotM, BadAddrM, valid_m
    );

    modport slave (
        input  pc_f, valid_f, stall_d, stall_e, stall_m, flush,
        input  invalid_d, syscall_d, break_d, eret_d, branch_d, ov_e,
        input  mem_addr_m, load_m, store_m, size_m,
        output ExceptTypeM, ExceptAddr, InDelaySlotM, BadAddrM, valid_m
    );

endinterface

// File: rtl/except_collect_exc_stage_reg.sv
// exc_stage_reg: one pipeline entry register with hold, bubble and flush.
// Flush beats hold, hold beats bubble, otherwise the entry is captured.
module exc_stage_reg
    import except_collect_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       hold,
    input  logic       bubble,
    input  exc_entry_t d,
    output exc_entry_t q
);

    // entry register: flush/bubble insert an empty entry, hold keeps it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) q <= '0;
            else        q <= d;
        end
    end

endmodule

// File: rtl/except_collect.sv
// except_collect: gathers F/D/E/M exception bits into an M-stage code.
// Optional memory alignment checks are enabled by EXC_MEM_ALIGN_EN.
module except_collect
    import except_collect_pkg::*;
(
    input logic           clock,
    input logic           reset,
    except_collect_if.slave bus
);

    exc_entry_t       fd_d, fd_q;
    exc_entry_t       de_d, de_q;
    exc_entry_t       em_d, em_q;
    logic [EXC_W-1:0] dec_exc;
    logic [EXC_W-1:0] align_exc;
    logic [EXC_W-1:0] exc_m;
    logic             adel_m;
    logic             ades_m;
    logic [31:0]      bad_addr;

    // fetch entry: PC alignment fault, delay-slot flag from the D entry
    always_comb begin
        fd_d = '0;
        fd_d.valid = bus.valid_f;
        fd_d.pc = bus.pc_f;
        fd_d.ds = fd_q.valid & bus.branch_d;
        fd_d.exc[EXC_ADEP] = bus.valid_f & (bus.pc_f[1:0] != 2'b00);
    end

    // decode faults merge only into a live D entry
    always_comb begin
        dec_exc = '0;
        dec_exc[EXC_INSTRINVALID] = bus.invalid_d;
        dec_exc[EXC_SYSCALL] = bus.syscall_d;
        dec_exc[EXC_BREAK] = bus.break_d;
        dec_exc[EXC_ERET] = bus.eret_d;
        de_d = fd_q;
        if (fd_q.valid) de_d.exc = fd_q.exc | dec_exc;
    end

    // overflow merges only into a live E entry
    always_comb begin
        em_d = de_q;
        em_d.exc[EXC_OV] = de_q.exc[EXC_OV] | (de_q.valid & bus.ov_e);
    end

    exc_stage_reg u_fd (
        .clock  (clock),
        .reset  (reset),
        .flush  (bus.flush),
        .hold   (bus.stall_d),
        .bubble (1'b0),
        .d      (fd_d),
        .q      (fd_q)
    );

    exc_stage_reg u_de (
        .clock  (clock),
        .reset  (reset),
        .flush  (bus.flush),
        .hold   (bus.stall_e),
        .bubble (bus.stall_d),
        .d      (de_d),
        .q      (de_q)
    );

    exc_stage_reg u_em (
        .clock  (clock),
        .reset  (reset),
        .flush  (bus.flush),
        .hold   (bus.stall_m),
        .bubble (bus.stall_e),
        .d      (em_d),
        .q      (em_q)
    );

`ifdef EXC_MEM_ALIGN_EN
    logic mis_m;

    // data access alignment, evaluated against the current M access
    always_comb begin
        mis_m = misaligned(bus.size_m, bus.mem_addr_m[1:0]);
        adel_m = bus.load_m & mis_m;
        ades_m = bus.store_m & mis_m;
    end

    // faulting address: fetch PC wins over data address
    always_comb begin
        bad_addr = ZEROWORD;
        if (exc_m[EXC_ADEP]) bad_addr = em_q.pc;
        else if (exc_m[EXC_ADEL] | exc_m[EXC_ADES])
            bad_addr = bus.mem_addr_m;
    end
`else
    logic unused_mem;

    assign adel_m = 1'b0;
    assign ades_m = 1'b0;
    assign unused_mem = ^{bus.mem_addr_m, bus.size_m,
                          bus.load_m, bus.store_m};

    // faulting address: only fetch PC faults are reported
    always_comb begin
        bad_addr = ZEROWORD;
        if (exc_m[EXC_ADEP]) bad_addr = em_q.pc;
    end
`endif

    // M exception code: entry bits plus alignment, silent on bubbles
    always_comb begin
        align_exc = '0;
        align_exc[EXC_ADEL] = adel_m;
        align_exc[EXC_ADES] = ades_m;
        exc_m = '0;
        if (em_q.valid) exc_m = em_q.exc | align_exc;
        exc_m[EXC_RSVD] = 1'b0;
    end

    assign bus.ExceptTypeM  = exc_m;
    assign bus.ExceptAddr   = em_q.pc + 32'd8;
    assign bus.InDelaySlotM = em_q.ds;
    assign bus.BadAddrM     = bad_addr;
    assign bus.valid_m      = em_q.valid;

endmodule

// File: tb/tb_except_collect.sv
// Directed self-checking bench for except_collect.
// Expected alignment results follow EXC_MEM_ALIGN_EN.
module tb_except_collect;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    except_collect_if bus ();

    except_collect dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef EXC_MEM_ALIGN_EN
    localparam logic [8:0]  EXP_LW  = 9'h040;
    localparam logic [8:0]  EXP_SH  = 9'h020;
    localparam logic [31:0] EXP_LWA = 32'h8000_0006;
`else
    localparam logic [8:0]  EXP_LW  = 9'h000;
    localparam logic [8:0]  EXP_SH  = 9'h000;
    localparam logic [31:0] EXP_LWA = 32'h0000_0000;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        bus.pc_f = '0; bus.valid_f = 0;
        bus.stall_d = 0; bus.stall_e = 0; bus.stall_m = 0;
        bus.flush = 0; bus.invalid_d = 0; bus.syscall_d = 0;
        bus.break_d = 0; bus.eret_d = 0; bus.branch_d = 0;
        bus.ov_e = 0; bus.mem_addr_m = '0; bus.load_m = 0;
        bus.store_m = 0; bus.size_m = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        n_total++;
        if (bus.ExceptTypeM !== 9'h000)
            $display("FAIL rst_type got=%h exp=000", bus.ExceptTypeM);
        else n_pass++;
        n_total++;
        if (bus.ExceptAddr !== 32'h8)
            $display("FAIL rst_addr got=%h exp=8", bus.ExceptAddr);
        else n_pass++;
        n_total++;
        if ({bus.valid_m, bus.InDelaySlotM, bus.BadAddrM} !== 34'h0)
            $display("FAIL rst_misc got=%b/%b/%h exp=0/0/0",
                     bus.valid_m, bus.InDelaySlotM, bus.BadAddrM);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_adep;
        bus.pc_f = 32'hBFC0_0002; bus.valid_f = 1;
        tick();
        bus.pc_f = '0; bus.valid_f = 0;
        tick();
        n_total++;
        if (bus.valid_m !== 1'b0)
            $display("FAIL adep_early got=%b exp=0", bus.valid_m);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ExceptTypeM !== 9'h001)
            $display("FAIL adep_type got=%h exp=001", bus.ExceptTypeM);
        else n_pass++;
        n_total++;
        if (bus.ExceptAddr !== 32'hBFC0_000A)
            $display("FAIL adep_addr got=%h exp=bfc0000a", bus.ExceptAddr);
        else n_pass++;
        n_total++;
        if (bus.BadAddrM !== 32'hBFC0_0002)
            $display("FAIL adep_bad got=%h exp=bfc00002", bus.BadAddrM);
        else n_pass++;
        tick();
        n_total++;
        if (bus.valid_m !== 1'b0)
            $display("FAIL adep_drain got=%b exp=0", bus.valid_m);
        else n_pass++;
    endtask

    task automatic test_delay_slot;
        bus.pc_f = 32'hBFC0_0100; bus.valid_f = 1;
        tick();
        bus.branch_d = 1;
        bus.pc_f = 32'hBFC0_0104;
        tick();
        bus.branch_d = 0; bus.syscall_d = 1;
        bus.valid_f = 0; bus.pc_f = '0;
        tick();
        bus.syscall_d = 0;
        n_total++;
        if ({bus.valid_m, bus.InDelaySlotM, bus.ExceptTypeM} !== {2'b10, 9'h0})
            $display("FAIL br_entry got=%b/%b/%h exp=1/0/000",
                     bus.valid_m, bus.InDelaySlotM, bus.ExceptTypeM);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ExceptTypeM !== 9'h008)
            $display("FAIL ds_type got=%h exp=008", bus.ExceptTypeM);
        else n_pass++;
        n_total++;
        if (bus.InDelaySlotM !== 1'b1)
            $display("FAIL ds_flag got=%b exp=1", bus.InDelaySlotM);
        else n_pass++;
        n_total++;
        if (bus.ExceptAddr !== 32'hBFC0_010C)
            $display("FAIL ds_addr got=%h exp=bfc0010c", bus.ExceptAddr);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_align;
        bus.pc_f = 32'h8000_1000; bus.valid_f = 1;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        tick();
        tick();
        bus.load_m = 1; bus.size_m = 2'd2;
        bus.mem_addr_m = 32'h8000_0006;
        #1;
        n_total++;
        if (bus.ExceptTypeM !== EXP_LW)
            $display("FAIL lw_type got=%h exp=%h", bus.ExceptTypeM, EXP_LW);
        else n_pass++;
        n_total++;
        if (bus.BadAddrM !== EXP_LWA)
            $display("FAIL lw_bad got=%h exp=%h", bus.BadAddrM, EXP_LWA);
        else n_pass++;
        bus.load_m = 0; bus.store_m = 1; bus.size_m = 2'd1;
        bus.mem_addr_m = 32'h8000_0003;
        #1;
        n_total++;
        if (bus.ExceptTypeM !== EXP_SH)
            $display("FAIL sh_type got=%h exp=%h", bus.ExceptTypeM, EXP_SH);
        else n_pass++;
        bus.size_m = 2'd0;
        #1;
        n_total++;
        if (bus.ExceptTypeM !== 9'h000)
            $display("FAIL sb_type got=%h exp=000", bus.ExceptTypeM);
        else n_pass++;
        bus.store_m = 0; bus.load_m = 1; bus.size_m = 2'd2;
        bus.mem_addr_m = 32'h8000_0008;
        #1;
        n_total++;
        if (bus.ExceptTypeM !== 9'h000)
            $display("FAIL lw_ok got=%h exp=000", bus.ExceptTypeM);
        else n_pass++;
        tick();
        bus.mem_addr_m = 32'h8000_0006;
        #1;
        n_total++;
        if (bus.ExceptTypeM !== 9'h000)
            $display("FAIL lw_bubble got=%h exp=000", bus.ExceptTypeM);
        else n_pass++;
        bus.load_m = 0; bus.size_m = '0; bus.mem_addr_m = '0;
    endtask

    task automatic test_stall_e;
        bus.pc_f = 32'h8000_0100; bus.valid_f = 1;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        tick();
        bus.stall_e = 1; bus.ov_e = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (bus.valid_m !== 1'b0)
                $display("FAIL ste_bubble%0d got=%b exp=0", i, bus.valid_m);
            else n_pass++;
        end
        bus.stall_e = 0;
        tick();
        bus.ov_e = 0;
        n_total++;
        if ({bus.valid_m, bus.ExceptTypeM} !== {1'b1, 9'h004})
            $display("FAIL ste_ov got=%b/%h exp=1/004",
                     bus.valid_m, bus.ExceptTypeM);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_m;
        bus.pc_f = 32'h8000_0202; bus.valid_f = 1;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        tick();
        tick();
        bus.stall_m = 1;
        tick();
        n_total++;
        if ({bus.valid_m, bus.ExceptTypeM} !== {1'b1, 9'h001})
            $display("FAIL stm_hold got=%b/%h exp=1/001",
                     bus.valid_m, bus.ExceptTypeM);
        else n_pass++;
        bus.stall_m = 0;
        tick();
        n_total++;
        if (bus.valid_m !== 1'b0)
            $display("FAIL stm_release got=%b exp=0", bus.valid_m);
        else n_pass++;
    endtask

    task automatic test_flush;
        bus.pc_f = 32'h8000_0201; bus.valid_f = 1;
        tick();
        bus.pc_f = 32'h8000_0204;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        bus.flush = 1; bus.stall_d = 1; bus.invalid_d = 1;
        tick();
        bus.flush = 0; bus.stall_d = 0; bus.invalid_d = 0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({bus.valid_m, bus.ExceptTypeM} !== 10'h0)
                $display("FAIL flush%0d got=%b/%h exp=0/000",
                         i, bus.valid_m, bus.ExceptTypeM);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_multi;
        bus.pc_f = 32'h8000_0401; bus.valid_f = 1;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        bus.invalid_d = 1; bus.break_d = 1; bus.eret_d = 1;
        tick();
        bus.invalid_d = 0; bus.break_d = 0; bus.eret_d = 0;
        tick();
        n_total++;
        if (bus.ExceptTypeM !== 9'h093)
            $display("FAIL multi_type got=%h exp=093", bus.ExceptTypeM);
        else n_pass++;
        n_total++;
        if (bus.BadAddrM !== 32'h8000_0401)
            $display("FAIL multi_bad got=%h exp=80000401", bus.BadAddrM);
        else n_pass++;
        bus.invalid_d = 1; bus.syscall_d = 1; bus.ov_e = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({bus.valid_m, bus.ExceptTypeM} !== 10'h0)
                $display("FAIL mask%0d got=%b/%h exp=0/000",
                         i, bus.valid_m, bus.ExceptTypeM);
            else n_pass++;
        end
        bus.invalid_d = 0; bus.syscall_d = 0; bus.ov_e = 0;
    endtask

    task automatic test_back_to_back;
        bus.valid_f = 1;
        bus.pc_f = 32'h8000_0002;
        tick();
        bus.pc_f = 32'h8000_0004;
        tick();
        bus.pc_f = 32'h8000_0009;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        n_total++;
        if ({bus.ExceptTypeM, bus.BadAddrM} !== {9'h001, 32'h8000_0002})
            $display("FAIL b2b0 got=%h/%h exp=001/80000002",
                     bus.ExceptTypeM, bus.BadAddrM);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.valid_m, bus.ExceptTypeM, bus.ExceptAddr, bus.BadAddrM}
            !== {1'b1, 9'h000, 32'h8000_000C, 32'h0})
            $display("FAIL b2b1 got=%b/%h/%h/%h exp=1/000/8000000c/0",
                     bus.valid_m, bus.ExceptTypeM,
                     bus.ExceptAddr, bus.BadAddrM);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.ExceptTypeM, bus.BadAddrM} !== {9'h001, 32'h8000_0009})
            $display("FAIL b2b2 got=%h/%h exp=001/80000009",
                     bus.ExceptTypeM, bus.BadAddrM);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset;
        bus.valid_f = 1;
        bus.pc_f = 32'h8000_0302;
        tick();
        bus.pc_f = 32'h8000_0306;
        tick();
        bus.valid_f = 0; bus.pc_f = '0;
        tick();
        n_total++;
        if (bus.ExceptTypeM !== 9'h001)
            $display("FAIL ar_pre got=%h exp=001", bus.ExceptTypeM);
        else n_pass++;
        #3;
        reset = 1'b0;
        #1;
        n_total++;
        if ({bus.valid_m, bus.ExceptTypeM, bus.ExceptAddr}
            !== {1'b0, 9'h000, 32'h8})
            $display("FAIL ar_now got=%b/%h/%h exp=0/000/8",
                     bus.valid_m, bus.ExceptTypeM, bus.ExceptAddr);
        else n_pass++;
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({bus.valid_m, bus.ExceptTypeM} !== 10'h0)
                $display("FAIL ar_post%0d got=%b/%h exp=0/000",
                         i, bus.valid_m, bus.ExceptTypeM);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_adep();
        test_delay_slot();
        test_mem_align();
        test_stall_e();
        test_stall_m();
        test_flush();
        test_multi();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
